// File: rtl/spike_pkg.sv
// Shared constants for the spike binning datapath: default FIFO depth,
// default per-bin count width and the packed bin word width.
package spike_pkg;
  localparam int DEPTH_LOG2_DEF = 6;
  localparam int CNT_W_DEF      = 8;
  localparam int WORD_W         = 16;
  localparam int WIN_W          = 16;
endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed bin words.
// Pointers carry one extra bit so full and empty are distinguishable.
module spike_fifo
  import spike_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WORD_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [WORD_W-1:0]     dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                pop_ok, push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
    ovf_d    = ovf_q | (push_i & full_o & ~pop_ok);
    unf_d    = unf_q | (pop_i & empty_o);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

  assign dout_o      = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/spike_bin_packer.sv
// Counts Ia/II spike edges into fixed-length time bins and queues each
// completed bin as {ii_cnt, ia_cnt} for the host pipe-out.
module spike_bin_packer
  import spike_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spike_ia,
  input  logic                spike_ii,
  input  logic [WIN_W-1:0]    window_len,
  input  logic                pipe_read,
  output logic [WORD_W-1:0]   dout,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic [31:0]         total_ia,
  output logic                overflow,
  output logic                underflow
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic            inc);
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic              ia_q, ii_q;
  logic [WIN_W-1:0]  bin_cnt_q, bin_cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  ia_cnt_q, ia_cnt_d;
  logic [CNT_W-1:0]  ii_cnt_q, ii_cnt_d;
  logic [31:0]       total_ia_q, total_ia_d;
  logic              ia_edge, ii_edge;
  logic [WIN_W-1:0]  win_eff;
  logic              bin_en, bin_last;
  logic [CNT_W-1:0]  ia_sum, ii_sum;
  logic [WORD_W-1:0] push_word;

  assign ia_edge = spike_ia & ~ia_q;
  assign ii_edge = spike_ii & ~ii_q;

  // The bin length is latched at bin start; mid-bin edits wait for the next bin.
  assign win_eff  = (bin_cnt_q == '0) ? window_len : win_q;
  assign bin_en   = (win_eff != '0);
  assign bin_last = bin_en && (bin_cnt_q == win_eff - WIN_W'(1));

  assign ia_sum    = sat_inc(ia_cnt_q, ia_edge);
  assign ii_sum    = sat_inc(ii_cnt_q, ii_edge);
  assign push_word = WORD_W'({ii_sum, ia_sum});

  always_comb begin
    bin_cnt_d  = bin_cnt_q + WIN_W'(1);
    ia_cnt_d   = ia_sum;
    ii_cnt_d   = ii_sum;
    win_d      = win_eff;
    total_ia_d = total_ia_q + {31'd0, ia_edge};
    if (!bin_en || bin_last) begin
      bin_cnt_d = '0;
      ia_cnt_d  = '0;
      ii_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ia_q       <= 1'b0;
      ii_q       <= 1'b0;
      bin_cnt_q  <= '0;
      win_q      <= '0;
      ia_cnt_q   <= '0;
      ii_cnt_q   <= '0;
      total_ia_q <= '0;
    end else begin
      ia_q       <= spike_ia;
      ii_q       <= spike_ii;
      bin_cnt_q  <= bin_cnt_d;
      win_q      <= win_d;
      ia_cnt_q   <= ia_cnt_d;
      ii_cnt_q   <= ii_cnt_d;
      total_ia_q <= total_ia_d;
    end
  end

  assign total_ia = total_ia_q;

  spike_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (bin_last),
    .push_data_i(push_word),
    .pop_i      (pipe_read),
    .dout_o     (dout),
    .empty_o    (empty),
    .full_o     (full),
    .level_o    (level),
    .overflow_o (overflow),
    .underflow_o(underflow)
  );

endmodule

// File: tb/tb_spike_bin_packer.sv
// Directed self-checking bench for spike_bin_packer.
module tb_spike_bin_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        spike_ia, spike_ii;
  logic [15:0] window_len;
  logic        pipe_read;
  logic [15:0] dout;
  logic        empty, full;
  logic [6:0]  level;
  logic [31:0] total_ia;
  logic        overflow, underflow;

  int checks = 0;
  int failures = 0;

  spike_bin_packer #(.DEPTH_LOG2(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .spike_ia(spike_ia), .spike_ii(spike_ii),
    .window_len(window_len), .pipe_read(pipe_read), .dout(dout),
    .empty(empty), .full(full), .level(level), .total_ia(total_ia),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic a, input logic b);
    spike_ia = a;
    spike_ii = b;
    step();
  endtask

  // Hold reset two cycles, then release; the cycle after release is bin cycle 0.
  task automatic start(input logic [15:0] win);
    reset = 1'b1;
    window_len = win;
    spike_ia = 1'b0;
    spike_ii = 1'b0;
    pipe_read = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; window_len = 16'd0; spike_ia = 0; spike_ii = 0; pipe_read = 0;
    step(); step();
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (level !== 7'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (total_ia !== 32'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_ia); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_basic_bin();
    start(16'd10);
    for (int c = 0; c < 10; c++) begin
      if (c == 9) begin
        checks++; if (level !== 7'd0) begin failures++; $display("FAIL basic_early_level got=%0d exp=0", level); end
      end
      cyc((c == 1) || (c == 3) || (c == 5), (c == 2));
    end
    checks++; if (dout !== 16'h0103) begin failures++; $display("FAIL basic_dout got=%h exp=0103", dout); end
    checks++; if (level !== 7'd1) begin failures++; $display("FAIL basic_level got=%0d exp=1", level); end
    checks++; if (total_ia !== 32'd3) begin failures++; $display("FAIL basic_total got=%0d exp=3", total_ia); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_empty got=%b exp=0", empty); end
  endtask

  task automatic test_held_level();
    start(16'd100);
    for (int c = 0; c < 100; c++) cyc(c < 50, 1'b0);
    checks++; if (dout !== 16'h0001) begin failures++; $display("FAIL held_dout got=%h exp=0001", dout); end
    checks++; if (total_ia !== 32'd1) begin failures++; $display("FAIL held_total got=%0d exp=1", total_ia); end
  endtask

  task automatic test_saturation();
    start(16'd1000);
    for (int c = 0; c < 1000; c++) cyc((c < 600) && (c % 2 == 0), 1'b0);
    checks++; if (dout !== 16'h00FF) begin failures++; $display("FAIL sat_dout got=%h exp=00ff", dout); end
    checks++; if (total_ia !== 32'd300) begin failures++; $display("FAIL sat_total got=%0d exp=300", total_ia); end
    checks++; if (level !== 7'd1) begin failures++; $display("FAIL sat_level got=%0d exp=1", level); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_w [64];
    int a, b;
    start(16'd4);
    for (int k = 0; k < 65; k++) begin
      a = k % 3;
      b = (k / 3) % 3;
      if (k < 64) exp_w[k] = {8'(b), 8'(a)};
      cyc(a >= 1, b >= 1);
      cyc(1'b0, 1'b0);
      cyc(a >= 2, b >= 2);
      cyc(1'b0, 1'b0);
      if (k == 63) begin
        checks++; if (level !== 7'd64) begin failures++; $display("FAIL ovf_fill_level got=%0d exp=64", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (level !== 7'd64) begin failures++; $display("FAIL ovf_level got=%0d exp=64", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    window_len = 16'd0;
    for (int i = 0; i < 64; i++) begin
      checks++; if (dout !== exp_w[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, dout, exp_w[i]); end
      pipe_read = 1'b1;
      step();
    end
    pipe_read = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drain_empty got=%b exp=1", empty); end
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL ovf_drain_dout got=%h exp=0000", dout); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL ovf_drain_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow_simul();
    start(16'd0);
    pipe_read = 1'b1;
    step();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL unf_dout got=%h exp=0000", dout); end
    checks++; if (level !== 7'd0) begin failures++; $display("FAIL unf_level got=%0d exp=0", level); end
    window_len = 16'd1;
    for (int c = 1; c <= 64; c++) begin
      pipe_read = (c == 1);
      cyc(c % 2 == 1, 1'b0);
      if (c == 1) begin
        checks++; if (level !== 7'd1) begin failures++; $display("FAIL empty_pushpop_level got=%0d exp=1", level); end
        checks++; if (dout !== 16'h0001) begin failures++; $display("FAIL empty_pushpop_dout got=%h exp=0001", dout); end
      end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", full); end
    pipe_read = 1'b1;
    cyc(1'b1, 1'b0);
    checks++; if (level !== 7'd64) begin failures++; $display("FAIL simul_level got=%0d exp=64", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
    checks++; if (dout !== 16'h0000 || empty !== 1'b0) begin failures++; $display("FAIL simul_head got=%h/%b exp=0000/0", dout, empty); end
    pipe_read = 1'b0;
    window_len = 16'd0;
    cyc(1'b0, 1'b0);
    checks++; if (level !== 7'd64) begin failures++; $display("FAIL simul_hold_level got=%0d exp=64", level); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL simul_unf_sticky got=%b exp=1", underflow); end
  endtask

  task automatic test_window_change();
    start(16'd4);
    cyc(1'b1, 1'b0);
    window_len = 16'd8;
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    checks++; if (level !== 7'd1 || dout !== 16'h0001) begin failures++; $display("FAIL win_first got=%0d/%h exp=1/0001", level, dout); end
    for (int c = 4; c < 11; c++) cyc(1'b0, 1'b0);
    checks++; if (level !== 7'd1) begin failures++; $display("FAIL win_long_early got=%0d exp=1", level); end
    cyc(1'b0, 1'b0);
    checks++; if (level !== 7'd2) begin failures++; $display("FAIL win_long_push got=%0d exp=2", level); end
  endtask

  task automatic test_mid_reset();
    start(16'd4);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    checks++; if (level !== 7'd5) begin failures++; $display("FAIL mid_pre_level got=%0d exp=5", level); end
    checks++; if (total_ia !== 32'd6) begin failures++; $display("FAIL mid_pre_total got=%0d exp=6", total_ia); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL mid_rst_dout got=%h exp=0000", dout); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b%b exp=10", empty, full); end
    checks++; if (level !== 7'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    checks++; if (total_ia !== 32'd0) begin failures++; $display("FAIL mid_rst_total got=%0d exp=0", total_ia); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL mid_rst_sticky got=%b%b exp=00", overflow, underflow); end
    step();
    reset = 1'b0;
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    checks++; if (dout !== 16'h0100) begin failures++; $display("FAIL mid_post_dout got=%h exp=0100", dout); end
    checks++; if (level !== 7'd1) begin failures++; $display("FAIL mid_post_level got=%0d exp=1", level); end
    checks++; if (total_ia !== 32'd0) begin failures++; $display("FAIL mid_post_total got=%0d exp=0", total_ia); end
  endtask

  initial begin
    test_reset();
    test_basic_bin();
    test_held_level();
    test_saturation();
    test_overflow();
    test_underflow_simul();
    test_window_change();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
